gf10_syndrome_acc: RTL
======================

GF10_SYNDROME_ACC -- requirements
Module: gf10_syndrome_acc

Interface
REQ-001 The module SHALL have parameter GF_LEN, default 10, meaning field width in bits; only 10 is supported.
REQ-002 The module SHALL have parameter CW_LEN, default 1023, meaning the number of codeword bits per frame (range 2..1023).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 The module SHALL have port in_start, input, 1, a one-cycle pulse that begins a new frame.
REQ-006 The module SHALL have port in_alpha, input, GF_LEN, the evaluation point alpha^j from the upstream GF counter, sampled at start.
REQ-007 The module SHALL have port in_bit_valid, input, 1, meaning in_bit carries a received codeword bit.
REQ-008 The module SHALL have port in_bit, input, 1, the received bit, highest-degree coefficient r(CW_LEN-1) first.
REQ-009 The module SHALL have port out_bit_ready, output, 1, meaning the block accepts a bit this cycle.
REQ-010 The module SHALL have port out_syndrome, output, GF_LEN, the accumulated syndrome S = r(in_alpha).
REQ-011 The module SHALL have port out_syn_valid, output, 1, meaning out_syndrome is final and held.
REQ-012 The module SHALL have port in_syn_ack, input, 1, the consumer acknowledge of out_syndrome.
REQ-013 The module SHALL have port out_zero, output, 1, meaning out_syn_valid=1 and out_syndrome==0.
REQ-014 The module SHALL have port out_busy, output, 1, meaning state is not IDLE.

Function
REQ-015 The GF multiply SHALL be combinational over GF(2^10) with primitive polynomial x^10+x^3+1 (0x409), polynomial basis, bit 0 = alpha^0.
REQ-016 The FSM SHALL have states IDLE, ACCUM and HOLD; out_bit_ready=1 only in ACCUM, and out_syn_valid=1 only in HOLD.
REQ-017 In IDLE, in_start=1 SHALL clear the accumulator S to 0 and the bit counter to 0, latch in_alpha into an internal alpha register, and enter ACCUM.
REQ-018 In ACCUM, each accepted bit (in_bit_valid & out_bit_ready) SHALL update S <= gf_mul(S, alpha_reg) XOR {0..0,in_bit} and increment the counter.
REQ-019 Cycles without an accepted bit SHALL leave S and the counter unchanged.
REQ-020 Acceptance of the CW_LEN-th bit SHALL move the FSM to HOLD; out_syn_valid rises the cycle after that bit is accepted, with latency 1.
REQ-021 In HOLD, out_syndrome and out_zero SHALL stay stable until in_syn_ack=1, which returns the FSM to IDLE.
REQ-022 In HOLD, in_syn_ack=1 with in_start=1 in the same cycle SHALL restart the frame directly (ACCUM, cleared state, new alpha latched).
REQ-023 in_start in HOLD without in_syn_ack SHALL be ignored.
REQ-024 in_start in ACCUM SHALL abort the current frame and restart as in REQ-017; any bit offered in that same cycle is discarded.
REQ-025 in_syn_ack outside HOLD and in_bit_valid outside ACCUM SHALL be ignored.
REQ-026 in_alpha changes after start SHALL NOT affect the running frame.
REQ-027 The counter SHALL be 10 bits wide and SHALL never wrap within a frame.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, S=0, counter=0, alpha_reg=0, out_bit_ready=0, out_syn_valid=0, out_zero=0, out_busy=0, asynchronously and including mid-frame; after rst deasserts, the block waits for in_start.

Verification
REQ-029 The bench SHALL check: in_alpha=0x002, 1023 zero bits -> out_syndrome=0x000, out_zero=1, out_syn_valid one cycle after the last bit.
REQ-030 The bench SHALL check: in_alpha=0x002, first bit 1 then 1022 zeros -> out_syndrome=0x204 (alpha^-1).
REQ-031 The bench SHALL check: in_alpha=0x002, only the last two bits 1 -> out_syndrome=0x003; with in_alpha=0x001 and random bits -> out_syndrome equals bit parity.
REQ-032 The bench SHALL check: in_bit_valid toggled randomly with gaps -> same syndrome as the gap-free run, and in_alpha changed mid-frame has no effect.
REQ-033 The bench SHALL check: in_start at bit 500 -> frame restarts; in HOLD without ack, in_start is ignored and the syndrome is held; ack+start in the same cycle -> ACCUM next cycle.
REQ-034 The bench SHALL check: rst pulsed mid-frame, asynchronously between clock edges -> all outputs 0 immediately, and a following full frame is computed correctly.

Source files
------------

// File: rtl/gf10_syndrome_acc.sv
// gf10_syndrome_acc: serial BCH/RS syndrome accumulator over GF(2^10).
// Horner evaluation of the received word r(x) at a latched point alpha.
module gf10_syndrome_acc #(
    parameter int GF_LEN = 10,
    parameter int CW_LEN = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_start,
    input  logic [GF_LEN-1:0] in_alpha,
    input  logic              in_bit_valid,
    input  logic              in_bit,
    output logic              out_bit_ready,
    output logic [GF_LEN-1:0] out_syndrome,
    output logic              out_syn_valid,
    input  logic              in_syn_ack,
    output logic              out_zero,
    output logic              out_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // x^10 = x^3 + 1 in this field, so an overflow folds back as 0x009
    localparam logic [GF_LEN-1:0] POLY_LO = GF_LEN'(10'h009);
    localparam logic [9:0]        LAST    = 10'(CW_LEN - 1);

    state_t            state, state_nxt;
    logic [GF_LEN-1:0] syn_q;
    logic [GF_LEN-1:0] alpha_q;
    logic [9:0]        cnt_q;
    logic              restart;
    logic              accept;
    logic              last_bit;

    function automatic logic [GF_LEN-1:0] gf_mul(
        input logic [GF_LEN-1:0] a,
        input logic [GF_LEN-1:0] b
    );
        logic [GF_LEN-1:0] p;
        p = '0;
        for (int i = GF_LEN - 1; i >= 0; i--) begin
            p = {p[GF_LEN-2:0], 1'b0} ^ (p[GF_LEN-1] ? POLY_LO : '0);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    // Frame (re)start and bit-acceptance qualifiers; a start wins over a bit
    always_comb begin
        restart  = 1'b0;
        unique case (state)
            IDLE:    restart = in_start;
            ACCUM:   restart = in_start;
            HOLD:    restart = in_start & in_syn_ack;
            default: restart = 1'b0;
        endcase
        accept   = (state == ACCUM) & in_bit_valid & ~in_start;
        last_bit = accept & (cnt_q == LAST);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_start) state_nxt = ACCUM;
            end
            ACCUM: begin
                if (in_start)      state_nxt = ACCUM;
                else if (last_bit) state_nxt = HOLD;
            end
            HOLD: begin
                if (in_syn_ack) state_nxt = in_start ? ACCUM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator, bit counter and latched evaluation point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syn_q   <= '0;
            cnt_q   <= '0;
            alpha_q <= '0;
        end else if (restart) begin
            syn_q   <= '0;
            cnt_q   <= '0;
            alpha_q <= in_alpha;
        end else if (accept) begin
            syn_q   <= gf_mul(syn_q, alpha_q) ^ {{(GF_LEN-1){1'b0}}, in_bit};
            cnt_q   <= cnt_q + 10'd1;
        end
    end

    // Outputs decoded from state
    always_comb begin
        out_bit_ready = (state == ACCUM);
        out_syn_valid = (state == HOLD);
        out_zero      = (state == HOLD) && (syn_q == '0);
        out_busy      = (state != IDLE);
        out_syndrome  = syn_q;
    end

endmodule
